// File: rtl/mips_pkg.sv
// Shared decode constants and control types for single_cycle_mips.
// Optional feature macro: MIPS_ADDI_EN (addi decode, used in single_cycle_mips).
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [4:0] RegRa = 5'd31;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbLink} wb_sel_e;
  typedef enum logic [1:0] {PcSeq, PcBr, PcJump, PcJr} pc_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    wb_sel_e    wb_sel;
    pc_sel_e    pc_sel;
    logic       alu_src_imm;
    logic       reg_we;
    logic [4:0] reg_waddr;
    logic       mem_rd;
    logic       mem_wr;
  } ctrl_t;

  // Wrapping arithmetic; slt is a signed compare producing 0 or 1.
  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    case (op)
      AluAdd:  res = a + b;
      AluSub:  res = a - b;
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluSlt:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one write port, $0 hardwired to zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next-state: apply the single write, never to $0.
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Register storage with synchronous clear (rst_n is active-high here).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= '{default: 32'd0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see only committed state; no write-through forwarding.
  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
  end

endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS subset core: PC, decoder, ALU, register file.
// Optional feature macro: MIPS_ADDI_EN enables addi (opcode 0x08); otherwise it is a NOP.
module single_cycle_mips
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] IR_addr,
  input  logic [31:0] IR,
  output logic [31:0] RF_writedata,
  input  logic [31:0] ReadDataMem,
  output logic        CEN,
  output logic        WEN,
  output logic [6:0]  A,
  output logic [31:0] ReadData2,
  output logic        OEN
);

  logic [31:0] pc_q, pc_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext;

  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_b, alu_res;
  logic [31:0] pc_plus4, br_target;
  logic [6:0]  mem_addr;
  logic        reg_we;
  ctrl_t       ctrl;

  logic unused_shamt;
  assign unused_shamt = ^IR[10:6];

  assign opcode   = IR[31:26];
  assign rs       = IR[25:21];
  assign rt       = IR[20:16];
  assign rd       = IR[15:11];
  assign funct    = IR[5:0];
  assign imm      = IR[15:0];
  assign target   = IR[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};

  // Decode opcode/funct into control; anything unrecognised stays a NOP.
  always_comb begin
    ctrl             = '0;
    ctrl.alu_op      = AluAdd;
    ctrl.wb_sel      = WbAlu;
    ctrl.pc_sel      = PcSeq;
    ctrl.alu_src_imm = 1'b0;
    ctrl.reg_we      = 1'b0;
    ctrl.reg_waddr   = 5'd0;
    ctrl.mem_rd      = 1'b0;
    ctrl.mem_wr      = 1'b0;
    case (opcode)
      OpRtype: begin
        ctrl.reg_waddr = rd;
        case (funct)
          FnAdd: begin ctrl.alu_op = AluAdd; ctrl.reg_we = 1'b1; end
          FnSub: begin ctrl.alu_op = AluSub; ctrl.reg_we = 1'b1; end
          FnAnd: begin ctrl.alu_op = AluAnd; ctrl.reg_we = 1'b1; end
          FnOr:  begin ctrl.alu_op = AluOr;  ctrl.reg_we = 1'b1; end
          FnSlt: begin ctrl.alu_op = AluSlt; ctrl.reg_we = 1'b1; end
          FnJr:  ctrl.pc_sel = PcJr;
          default: ;
        endcase
      end
      OpLw: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.reg_we    = 1'b1;
        ctrl.reg_waddr = rt;
        ctrl.wb_sel    = WbMem;
      end
      OpSw:  ctrl.mem_wr = 1'b1;
      OpBeq: begin
        ctrl.alu_op = AluSub;
        ctrl.pc_sel = PcBr;
      end
      OpJ:   ctrl.pc_sel = PcJump;
      OpJal: begin
        ctrl.pc_sel    = PcJump;
        ctrl.reg_we    = 1'b1;
        ctrl.reg_waddr = RegRa;
        ctrl.wb_sel    = WbLink;
      end
`ifdef MIPS_ADDI_EN
      OpAddi: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_we      = 1'b1;
        ctrl.reg_waddr   = rt;
      end
`endif
      default: ;
    endcase
  end

  // Nothing is committed on an edge where reset is asserted.
  assign reg_we = ctrl.reg_we & ~rst_n;

  mips_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val),
    .we_i     (reg_we),
    .waddr_i  (ctrl.reg_waddr),
    .wdata_i  (RF_writedata)
  );

  // ALU and write-back selection.
  always_comb begin
    alu_b   = ctrl.alu_src_imm ? imm_sext : rt_val;
    alu_res = alu_eval(ctrl.alu_op, rs_val, alu_b);
    case (ctrl.wb_sel)
      WbMem:   RF_writedata = ReadDataMem;
      WbLink:  RF_writedata = pc_plus4;
      default: RF_writedata = alu_res;
    endcase
  end

  // SRAM interface; a word index, so only the low 7 bits of rs+imm matter.
  always_comb begin
    mem_addr  = rs_val[6:0] + imm_sext[6:0];
    A         = mem_addr;
    ReadData2 = rt_val;
    CEN       = rst_n | ~(ctrl.mem_rd | ctrl.mem_wr);
    WEN       = rst_n | ~ctrl.mem_wr;
    OEN       = rst_n;
  end

  // Next-PC selection; redirects take effect on the committing edge.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    case (ctrl.pc_sel)
      PcBr:    pc_d = (rs_val == rt_val) ? br_target : pc_plus4;
      PcJump:  pc_d = {pc_plus4[31:28], target, 2'b00};
      PcJr:    pc_d = rs_val;
      default: pc_d = pc_plus4;
    endcase
  end

  // Program counter with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign IR_addr = pc_q;

endmodule

// File: tb/tb_single_cycle_mips.sv
// Directed self-checking bench for single_cycle_mips with ROM and falling-edge SRAM models.
module tb_single_cycle_mips;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_addr, IR, RF_writedata, ReadDataMem, ReadData2;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;

  logic [31:0] rom [128];
  logic [31:0] mem [128];
  logic        mem_ready = 1'b0;
  logic [31:0] sram_q = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  single_cycle_mips dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR_addr      (IR_addr),
    .IR           (IR),
    .RF_writedata (RF_writedata),
    .ReadDataMem  (ReadDataMem),
    .CEN          (CEN),
    .WEN          (WEN),
    .A            (A),
    .ReadData2    (ReadData2),
    .OEN          (OEN)
  );

  assign IR          = rom[IR_addr[8:2]];
  assign ReadDataMem = sram_q;

  // Falling-edge SRAM; preloaded on its first edge (reset holds CEN high then).
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd15;
      mem[1] <= 32'd20;
      mem[2] <= 32'h7FFF_FFFF;
      mem[3] <= 32'd1;
      mem[5] <= 32'hFFFF_FFFF;
      mem_ready <= 1'b1;
    end else if (!CEN) begin
      if (!WEN) mem[A] <= ReadData2;
      else      sram_q <= mem[A];
    end
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the sample point of the next instruction (after the SRAM edge).
  task automatic next_instr();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'd0;
    rom[0]  = i_ins(6'h23, 5'd0, 5'd8, 16'd0);        // lw   $t0,0
    rom[1]  = i_ins(6'h23, 5'd0, 5'd9, 16'd1);        // lw   $t1,1
    rom[2]  = r_ins(5'd8, 5'd8, 5'd10, 6'h20);        // add  $t2,$t0,$t0
    rom[3]  = r_ins(5'd10, 5'd9, 5'd11, 6'h22);       // sub  $t3,$t2,$t1
    rom[4]  = r_ins(5'd9, 5'd10, 5'd16, 6'h24);       // and  $s0,$t1,$t2
    rom[5]  = i_ins(6'h04, 5'd8, 5'd9, 16'd5);        // beq  $t0,$t1 (not taken)
    rom[6]  = r_ins(5'd9, 5'd10, 5'd12, 6'h25);       // or   $t4,$t1,$t2
    rom[7]  = r_ins(5'd8, 5'd9, 5'd13, 6'h2A);        // slt  $t5,$t0,$t1
    rom[8]  = i_ins(6'h2B, 5'd0, 5'd12, 16'd4);       // sw   $t4,4
    rom[9]  = i_ins(6'h23, 5'd0, 5'd17, 16'd4);       // lw   $s1,4
    rom[10] = j_ins(6'h02, 26'd13);                   // j    52
    rom[11] = r_ins(5'd8, 5'd8, 5'd0, 6'h20);         // add  $0,$t0,$t0
    rom[12] = r_ins(5'd31, 5'd0, 5'd0, 6'h08);        // jr   $ra
    rom[13] = i_ins(6'h23, 5'd0, 5'd18, 16'd2);       // lw   $s2,2
    rom[14] = j_ins(6'h03, 26'd11);                   // jal  44
    rom[15] = i_ins(6'h04, 5'd8, 5'd8, 16'd2);        // beq  $t0,$t0 -> 72
    rom[16] = r_ins(5'd0, 5'd0, 5'd20, 6'h20);        // skipped
    rom[17] = r_ins(5'd0, 5'd0, 5'd20, 6'h20);        // skipped
    rom[18] = r_ins(5'd31, 5'd16, 5'd20, 6'h20);      // add  $s4,$ra,$s0
    rom[19] = r_ins(5'd0, 5'd0, 5'd14, 6'h20);        // add  $t6,$0,$0
    rom[20] = i_ins(6'h23, 5'd0, 5'd19, 16'd3);       // lw   $s3,3
    rom[21] = r_ins(5'd18, 5'd19, 5'd21, 6'h20);      // add  $s5,$s2,$s3
    rom[22] = i_ins(6'h23, 5'd0, 5'd22, 16'd5);       // lw   $s6,5
    rom[23] = r_ins(5'd22, 5'd19, 5'd23, 6'h2A);      // slt  $s7,$s6,$s3
    rom[24] = i_ins(6'h08, 5'd0, 5'd8, 16'hFFFD);     // addi $t0,$0,-3
    rom[25] = r_ins(5'd8, 5'd0, 5'd15, 6'h20);        // add  $t7,$t0,$0
    rom[26] = r_ins(5'd8, 5'd8, 5'd8, 6'h21);         // unknown funct: NOP
    rom[27] = r_ins(5'd8, 5'd0, 5'd15, 6'h20);        // add  $t7,$t0,$0
    rom[28] = j_ins(6'h02, 26'd28);                   // spin

    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_eq("rst_pc", IR_addr, 32'd0);
    check_eq("rst_cen", {31'd0, CEN}, 32'd1);
    check_eq("rst_wen", {31'd0, WEN}, 32'd1);
    check_eq("rst_oen", {31'd0, OEN}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #2;

    check_eq("pc0", IR_addr, 32'd0);
    check_eq("lw0_cen", {31'd0, CEN}, 32'd0);
    check_eq("lw0_wen", {31'd0, WEN}, 32'd1);
    check_eq("lw0_oen", {31'd0, OEN}, 32'd0);
    check_eq("lw0_wd", RF_writedata, 32'd15);
    next_instr(); check_eq("lw1_wd", RF_writedata, 32'd20);
    next_instr(); check_eq("add_wd", RF_writedata, 32'd30);
    check_eq("add_cen", {31'd0, CEN}, 32'd1);
    next_instr(); check_eq("sub_wd", RF_writedata, 32'd10);
    next_instr(); check_eq("and_wd", RF_writedata, 32'd20);
    next_instr(); check_eq("beq_nt_pc", IR_addr, 32'd20);
    next_instr(); check_eq("after_beq_pc", IR_addr, 32'd24);
    check_eq("or_wd", RF_writedata, 32'd30);
    next_instr(); check_eq("slt_wd", RF_writedata, 32'd1);
    next_instr(); check_eq("sw_pc", IR_addr, 32'd32);
    check_eq("sw_cen", {31'd0, CEN}, 32'd0);
    check_eq("sw_wen", {31'd0, WEN}, 32'd0);
    check_eq("sw_a", {25'd0, A}, 32'd4);
    check_eq("sw_rd2", ReadData2, 32'd30);
    next_instr(); check_eq("lw4_wd", RF_writedata, 32'd30);
    next_instr(); check_eq("j_pc", IR_addr, 32'd40);
    next_instr(); check_eq("j_tgt_pc", IR_addr, 32'd52);
    check_eq("lw2_wd", RF_writedata, 32'h7FFF_FFFF);
    next_instr(); check_eq("jal_pc", IR_addr, 32'd56);
    check_eq("jal_wd", RF_writedata, 32'd60);
    next_instr(); check_eq("jal_tgt_pc", IR_addr, 32'd44);
    check_eq("add_r0_wd", RF_writedata, 32'd30);
    next_instr(); check_eq("jr_pc", IR_addr, 32'd48);
    next_instr(); check_eq("jr_tgt_pc", IR_addr, 32'd60);
    next_instr(); check_eq("beq_t_pc", IR_addr, 32'd72);
    check_eq("s4_wd", RF_writedata, 32'd80);
    next_instr(); check_eq("r0_zero", RF_writedata, 32'd0);
    next_instr(); check_eq("lw3_wd", RF_writedata, 32'd1);
    next_instr(); check_eq("wrap_wd", RF_writedata, 32'h8000_0000);
    next_instr(); check_eq("lw5_wd", RF_writedata, 32'hFFFF_FFFF);
    next_instr(); check_eq("slt_neg", RF_writedata, 32'd1);
    next_instr(); check_eq("addi_pc", IR_addr, 32'd96);
`ifdef MIPS_ADDI_EN
    check_eq("addi_wd", RF_writedata, 32'hFFFF_FFFD);
    next_instr(); check_eq("t0_after_addi", RF_writedata, 32'hFFFF_FFFD);
    next_instr(); next_instr();
    check_eq("nop_funct", RF_writedata, 32'hFFFF_FFFD);
`else
    next_instr(); check_eq("t0_after_addi", RF_writedata, 32'd15);
    next_instr(); next_instr();
    check_eq("nop_funct", RF_writedata, 32'd15);
`endif
    check_eq("pc108", IR_addr, 32'd108);
    next_instr(); check_eq("spin_pc", IR_addr, 32'd112);

    // Mid-program reset
    rst_n = 1'b1;
    #1;
    check_eq("mrst_cen", {31'd0, CEN}, 32'd1);
    check_eq("mrst_wen", {31'd0, WEN}, 32'd1);
    check_eq("mrst_oen", {31'd0, OEN}, 32'd1);
    next_instr(); check_eq("mrst_pc", IR_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check_eq("rerun_pc", IR_addr, 32'd0);
    check_eq("rerun_lw", RF_writedata, 32'd15);
    next_instr(); next_instr();
    check_eq("rerun_add", RF_writedata, 32'd30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
